xc_wb_pipe_2: RTL and testbench

XC_WB_PIPE_2 -- requirements
Module: xc_wb_pipe_2

---
 rtl/xc_wb_pipe_2.sv | 165 ++++++++++++++++
 tb/tb_xc_wb_pipe_2.sv | 208 ++++++++++++++++++++
 2 files changed

// File: rtl/xc_wb_pipe_2.sv
// xc_wb_pipe_2 -- three-stage writeback pipeline (S0 -> S1 -> S2) with
// forwarding taps and a register-file write port.
//
// A narrow result is accepted straight into S0. A wide result is split into
// two beats. The low word goes to the even register on the accepting edge.
// The high word is held internally and goes to the odd register on the next
// edge, while ex_ready is low. The stages always advance, and empty slots
// move through as bubbles. flush drops everything that has not yet reached
// the rd stage.
//
// Ports:
//   clock, reset            sole clock; asynchronous active-high reset
//   ex_valid / ex_ready     execute-result handshake
//   ex_wide                 paired write (even reg <- lo, odd reg <- hi)
//   ex_rd_addr              destination register (bit 0 ignored when wide)
//   ex_wdata / ex_wdata_hi  result / high word
//   flush                   discard all entries not yet in rd
//   fwd_0_*                 stage S0 (youngest) forwarding tap
//   fwd_1_*                 stage S1 forwarding tap
//   rd_*                    stage S2 (oldest) register-file write port
//   pend                    bit n set while any in-flight entry targets reg n
//
// Configuration:
//   XC_WB_PEND_EN  defined   -> pend decoded from the stage and captured addrs
//                  undefined -> pend tied to zero and no decode logic is built
module xc_wb_pipe_2 (
  input  logic        clock,
  input  logic        reset,
  input  logic        ex_valid,
  output logic        ex_ready,
  input  logic        ex_wide,
  input  logic [4:0]  ex_rd_addr,
  input  logic [31:0] ex_wdata,
  input  logic [31:0] ex_wdata_hi,
  input  logic        flush,
  output logic        fwd_0_wen,
  output logic [4:0]  fwd_0_addr,
  output logic [31:0] fwd_0_wdata,
  output logic        fwd_1_wen,
  output logic [4:0]  fwd_1_addr,
  output logic [31:0] fwd_1_wdata,
  output logic        rd_wen,
  output logic [4:0]  rd_addr,
  output logic [31:0] rd_wdata,
  output logic [31:0] pend
);

  localparam int STAGES = 2;

  typedef enum logic {RUN, HI} state_t;

  state_t                   state, state_nx;
  logic [STAGES:0]          vld_pipe;
  logic [STAGES:0][4:0]     addr_pipe;
  logic [STAGES:0][31:0]    data_pipe;
  logic [4:0]               hi_addr, hi_addr_nx;
  logic [31:0]              hi_data, hi_data_nx;
  logic                     s0_vld_nx;
  logic [4:0]               s0_addr_nx;
  logic [31:0]              s0_data_nx;

  // Next-state logic, S0 load selection and the ready handshake.
  always_comb begin
    state_nx   = state;
    hi_addr_nx = hi_addr;
    hi_data_nx = hi_data;
    ex_ready   = 1'b0;
    s0_vld_nx  = 1'b0;
    s0_addr_nx = '0;
    s0_data_nx = '0;
    case (state)
      RUN: begin
        // Reset is included because the FSM already sits in RUN while reset
        // is held. Without it, ready could rise before the first usable edge.
        ex_ready = !flush && !reset;
        if (ex_valid && ex_ready) begin
          s0_vld_nx  = 1'b1;
          s0_data_nx = ex_wdata;
          if (ex_wide) begin
            s0_addr_nx = ex_rd_addr & 5'b11110;
            hi_addr_nx = ex_rd_addr | 5'b00001;
            hi_data_nx = ex_wdata_hi;
            state_nx   = HI;
          end else begin
            s0_addr_nx = ex_rd_addr;
          end
        end
      end
      HI: begin
        s0_vld_nx  = 1'b1;
        s0_addr_nx = hi_addr;
        s0_data_nx = hi_data;
        hi_addr_nx = '0;
        hi_data_nx = '0;
        state_nx   = RUN;
      end
      default: state_nx = RUN;
    endcase
    if (flush) begin
      s0_vld_nx  = 1'b0;
      hi_addr_nx = '0;
      hi_data_nx = '0;
      state_nx   = RUN;
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state   <= RUN;
      hi_addr <= '0;
      hi_data <= '0;
    end else begin
      state   <= state_nx;
      hi_addr <= hi_addr_nx;
      hi_data <= hi_data_nx;
    end
  end

  // The stages shift every cycle. flush kills the S0 and S1 occupants as they
  // move down. The S2 occupant still drives rd during the flush cycle, so its
  // write is kept.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      vld_pipe  <= '0;
      addr_pipe <= '0;
      data_pipe <= '0;
    end else begin
      vld_pipe[0]  <= s0_vld_nx;
      addr_pipe[0] <= s0_addr_nx;
      data_pipe[0] <= s0_data_nx;
      for (int i = 1; i <= STAGES; i++) begin
        vld_pipe[i]  <= vld_pipe[i-1] & ~flush;
        addr_pipe[i] <= addr_pipe[i-1];
        data_pipe[i] <= data_pipe[i-1];
      end
    end
  end

  // x0 writes travel down the pipe but are never enabled.
  assign fwd_0_wen   = vld_pipe[0] && (addr_pipe[0] != 5'd0);
  assign fwd_0_addr  = addr_pipe[0];
  assign fwd_0_wdata = data_pipe[0];
  assign fwd_1_wen   = vld_pipe[1] && (addr_pipe[1] != 5'd0);
  assign fwd_1_addr  = addr_pipe[1];
  assign fwd_1_wdata = data_pipe[1];
  assign rd_wen      = vld_pipe[2] && (addr_pipe[2] != 5'd0);
  assign rd_addr     = addr_pipe[2];
  assign rd_wdata    = data_pipe[2];

`ifdef XC_WB_PEND_EN
  // The captured hi address counts as pending as soon as the wide op is
  // accepted, so a consumer never sees the odd register as free in the gap
  // before its beat enters S0.
  always_comb begin
    pend = '0;
    for (int i = 0; i <= STAGES; i++) begin
      if (vld_pipe[i] && (addr_pipe[i] != 5'd0)) pend[addr_pipe[i]] = 1'b1;
    end
    if (state == HI) pend[hi_addr] = 1'b1;
  end
`else
  assign pend = 32'h0;
`endif

endmodule

// File: tb/tb_xc_wb_pipe_2.sv
// Directed bench for xc_wb_pipe_2. It covers reset, narrow and wide writes,
// x0 suppression, flush, reset in the middle of a wide op, and back-to-back
// streaming. Expected values are hand-computed constants.
module tb_xc_wb_pipe_2;

  logic        clock = 1'b0;
  logic        reset;
  logic        ex_valid, ex_ready, ex_wide, flush;
  logic [4:0]  ex_rd_addr;
  logic [31:0] ex_wdata, ex_wdata_hi;
  logic        fwd_0_wen, fwd_1_wen, rd_wen;
  logic [4:0]  fwd_0_addr, fwd_1_addr, rd_addr;
  logic [31:0] fwd_0_wdata, fwd_1_wdata, rd_wdata, pend;

  int checks   = 0;
  int failures = 0;

  xc_wb_pipe_2 dut (
    .clock(clock), .reset(reset),
    .ex_valid(ex_valid), .ex_ready(ex_ready), .ex_wide(ex_wide),
    .ex_rd_addr(ex_rd_addr), .ex_wdata(ex_wdata), .ex_wdata_hi(ex_wdata_hi),
    .flush(flush),
    .fwd_0_wen(fwd_0_wen), .fwd_0_addr(fwd_0_addr), .fwd_0_wdata(fwd_0_wdata),
    .fwd_1_wen(fwd_1_wen), .fwd_1_addr(fwd_1_addr), .fwd_1_wdata(fwd_1_wdata),
    .rd_wen(rd_wen), .rd_addr(rd_addr), .rd_wdata(rd_wdata),
    .pend(pend)
  );

  always #5 clock = ~clock;

  task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s act=%h exp=%h", tag, act, exp);
    end
  endtask

  // Expected pend value: the decoded mask when the feature is built, else zero.
  function automatic logic [31:0] pexp(input logic [31:0] m);
`ifdef XC_WB_PEND_EN
    return m;
`else
    return 32'h0 & m;
`endif
  endfunction

  // Advance one rising edge; sample 1 time unit later.
  task automatic step();
    @(posedge clock);
    #1;
  endtask

  task automatic drive(input logic v, input logic w, input logic [4:0] a,
                       input logic [31:0] lo, input logic [31:0] hi);
    ex_valid = v; ex_wide = w; ex_rd_addr = a; ex_wdata = lo; ex_wdata_hi = hi;
  endtask

  initial begin
    reset = 1'b1; flush = 1'b0;
    drive(1'b1, 1'b0, 5'd3, 32'h1234, 32'h0);
    #2;
    chk("rst_ready", {31'd0, ex_ready}, 32'd0);
    chk("rst_rd_wen", {31'd0, rd_wen}, 32'd0);
    chk("rst_f0_wen", {31'd0, fwd_0_wen}, 32'd0);
    chk("rst_pend", pend, 32'h0);
    step(); step();
    chk("rst_rd_addr", {27'd0, rd_addr}, 32'd0);
    chk("rst_rd_data", rd_wdata, 32'h0);
    chk("rst_ready2", {31'd0, ex_ready}, 32'd0);
    drive(1'b0, 1'b0, 5'd0, 32'h0, 32'h0);
    reset = 1'b0;
    #1;
    chk("post_rst_ready", {31'd0, ex_ready}, 32'd1);

    // Narrow write to x5.
    drive(1'b1, 1'b0, 5'd5, 32'hDEADBEEF, 32'h0);
    step();
    drive(1'b0, 1'b0, 5'd0, 32'h0, 32'h0);
    chk("n_f0_wen", {31'd0, fwd_0_wen}, 32'd1);
    chk("n_f0_addr", {27'd0, fwd_0_addr}, 32'd5);
    chk("n_f0_data", fwd_0_wdata, 32'hDEADBEEF);
    chk("n_pend1", pend, pexp(32'h20));
    step();
    chk("n_f1_wen", {31'd0, fwd_1_wen}, 32'd1);
    chk("n_f1_addr", {27'd0, fwd_1_addr}, 32'd5);
    chk("n_f0_bubble", {31'd0, fwd_0_wen}, 32'd0);
    chk("n_pend2", pend, pexp(32'h20));
    step();
    chk("n_rd_wen", {31'd0, rd_wen}, 32'd1);
    chk("n_rd_addr", {27'd0, rd_addr}, 32'd5);
    chk("n_rd_data", rd_wdata, 32'hDEADBEEF);
    chk("n_pend3", pend, pexp(32'h20));
    step();
    chk("n_rd_done", {31'd0, rd_wen}, 32'd0);
    chk("n_pend4", pend, 32'h0);

    // Wide write to x6/x7.
    drive(1'b1, 1'b1, 5'd7, 32'h11111111, 32'h22222222);
    #1;
    chk("w_ready_pre", {31'd0, ex_ready}, 32'd1);
    step();
    chk("w_ready_hi", {31'd0, ex_ready}, 32'd0);
    chk("w_f0_addr_lo", {27'd0, fwd_0_addr}, 32'd6);
    chk("w_f0_data_lo", fwd_0_wdata, 32'h11111111);
    chk("w_pend_hi", pend, pexp(32'hC0));
    drive(1'b0, 1'b0, 5'd0, 32'h0, 32'h0);
    step();
    chk("w_f0_addr_hi", {27'd0, fwd_0_addr}, 32'd7);
    chk("w_f0_data_hi", fwd_0_wdata, 32'h22222222);
    chk("w_f1_addr", {27'd0, fwd_1_addr}, 32'd6);
    chk("w_ready_back", {31'd0, ex_ready}, 32'd1);
    step();
    chk("w_rd_lo_wen", {31'd0, rd_wen}, 32'd1);
    chk("w_rd_lo_addr", {27'd0, rd_addr}, 32'd6);
    chk("w_rd_lo_data", rd_wdata, 32'h11111111);
    step();
    chk("w_rd_hi_wen", {31'd0, rd_wen}, 32'd1);
    chk("w_rd_hi_addr", {27'd0, rd_addr}, 32'd7);
    chk("w_rd_hi_data", rd_wdata, 32'h22222222);
    step();
    chk("w_rd_done", {31'd0, rd_wen}, 32'd0);

    // Write to x0: carried through the pipe but never enabled.
    drive(1'b1, 1'b0, 5'd0, 32'hFFFFFFFF, 32'h0);
    step();
    drive(1'b0, 1'b0, 5'd0, 32'h0, 32'h0);
    chk("x0_f0_wen", {31'd0, fwd_0_wen}, 32'd0);
    chk("x0_f0_data", fwd_0_wdata, 32'hFFFFFFFF);
    chk("x0_pend", pend, 32'h0);
    step();
    chk("x0_f1_wen", {31'd0, fwd_1_wen}, 32'd0);
    step();
    chk("x0_rd_wen", {31'd0, rd_wen}, 32'd0);
    chk("x0_rd_data", rd_wdata, 32'hFFFFFFFF);
    step();

    // Flush: x1,x2,x3 back to back; flush while x1 is in S2.
    for (int i = 1; i <= 3; i++) begin
      drive(1'b1, 1'b0, 5'(i), 32'h100 + 32'(i), 32'h0);
      step();
    end
    drive(1'b1, 1'b0, 5'd4, 32'h104, 32'h0);
    flush = 1'b1;
    #1;
    chk("fl_ready", {31'd0, ex_ready}, 32'd0);
    chk("fl_rd_wen", {31'd0, rd_wen}, 32'd1);
    chk("fl_rd_addr", {27'd0, rd_addr}, 32'd1);
    chk("fl_rd_data", rd_wdata, 32'h101);
    step();
    flush = 1'b0;
    drive(1'b0, 1'b0, 5'd0, 32'h0, 32'h0);
    chk("fl_f0_wen", {31'd0, fwd_0_wen}, 32'd0);
    chk("fl_f1_wen", {31'd0, fwd_1_wen}, 32'd0);
    chk("fl_rd_wen1", {31'd0, rd_wen}, 32'd0);
    chk("fl_pend", pend, 32'h0);
    step();
    chk("fl_rd_wen2", {31'd0, rd_wen}, 32'd0);
    step();
    chk("fl_rd_wen3", {31'd0, rd_wen}, 32'd0);

    // Reset while the wide op to x8/x9 is in HI.
    drive(1'b1, 1'b1, 5'd8, 32'hAAAA0000, 32'hBBBB0000);
    step();
    drive(1'b0, 1'b0, 5'd0, 32'h0, 32'h0);
    chk("rm_f0_addr", {27'd0, fwd_0_addr}, 32'd8);
    chk("rm_pend_pre", pend, pexp(32'h300));
    reset = 1'b1;
    #1;
    chk("rm_f0_wen", {31'd0, fwd_0_wen}, 32'd0);
    chk("rm_rd_wen", {31'd0, rd_wen}, 32'd0);
    chk("rm_ready", {31'd0, ex_ready}, 32'd0);
    chk("rm_pend", pend, 32'h0);
    step();
    reset = 1'b0;
    for (int i = 0; i < 3; i++) begin
      step();
      chk("rm_no_f0", {31'd0, fwd_0_wen}, 32'd0);
      chk("rm_no_rd", {31'd0, rd_wen}, 32'd0);
    end

    // Back-to-back: ten narrow writes with addresses 1..10.
    for (int i = 1; i <= 10; i++) begin
      drive(1'b1, 1'b0, 5'(i), 32'h1000 + 32'(i), 32'h0);
      #1;
      chk("bb_ready", {31'd0, ex_ready}, 32'd1);
      step();
      chk("bb_f0_addr", {27'd0, fwd_0_addr}, 32'(i));
      if (i >= 3) begin
        chk("bb_rd_wen", {31'd0, rd_wen}, 32'd1);
        chk("bb_rd_addr", {27'd0, rd_addr}, 32'(i - 2));
        chk("bb_rd_data", rd_wdata, 32'h1000 + 32'(i - 2));
      end
    end
    drive(1'b0, 1'b0, 5'd0, 32'h0, 32'h0);
    step();
    chk("bb_rd_addr9", {27'd0, rd_addr}, 32'd9);
    step();
    chk("bb_rd_addr10", {27'd0, rd_addr}, 32'd10);
    chk("bb_rd_data10", rd_wdata, 32'h100A);
    step();
    chk("bb_rd_end", {31'd0, rd_wen}, 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
